// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared AES inverse-cipher constants, controller state encoding and byte-level
// transforms used by the inverse round datapath.
package aes_inv_round_ctrl_pkg;

  localparam int unsigned AesNr = 10;
  localparam int unsigned AesW  = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRound = 2'b01,
    StFinal = 2'b10
  } aes_ctrl_st_e;

  // Byte n of the FIPS-197 input ordering (n = row + 4*col) lives at index 15-n.
  typedef logic [15:0][7:0] aes_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Undo the affine map, then invert in GF(2^8) as x^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] r;
    b  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq = b;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[15-(r+4*c)] = s[15-(r+4*((c+4-r)%4))];
      end
    end
    return o;
  endfunction

  function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
    aes_state_t o;
    for (int n = 0; n < 16; n++) begin
      o[n] = inv_sbox(s[n]);
    end
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[15-4*c];
      a1 = s[14-4*c];
      a2 = s[13-4*c];
      a3 = s[12-4*c];
      o[15-4*c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[14-4*c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[13-4*c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[12-4*c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last_i is set, InvMixColumns.
module aes_inv_round
  import aes_inv_round_ctrl_pkg::*;
(
  input  logic [AesW-1:0] data_i,
  input  logic [AesW-1:0] rk_i,
  input  logic            last_i,
  output logic [AesW-1:0] data_o
);

  aes_state_t ark;

  always_comb begin
    ark    = inv_sub_bytes(inv_shift_rows(data_i)) ^ rk_i;
    data_o = last_i ? ark : inv_mix_columns(ark);
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per cycle, round keys
// fetched combinationally from an external store addressed by rk_idx.
module aes_inv_round_ctrl
  import aes_inv_round_ctrl_pkg::*;
#(
  parameter int unsigned NR = AesNr,
  parameter int unsigned W  = AesW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [W-1:0] rk,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] plaintext
);

  aes_ctrl_st_e st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] pt_q, pt_d;
  logic         done_q, done_d;
  logic [W-1:0] round_out;
  logic         last;

  aes_inv_round u_round (
    .data_i (data_q),
    .rk_i   (rk),
    .last_i (last),
    .data_o (round_out)
  );

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    pt_d   = pt_q;
    done_d = 1'b0;
    rk_idx = 4'(NR);
    last   = 1'b0;
    case (st_q)
      StIdle: begin
        if (start) begin
          data_d = ciphertext ^ rk;
          cnt_d  = 4'(NR - 1);
          st_d   = StRound;
        end
      end
      StRound: begin
        rk_idx = cnt_q;
        data_d = round_out;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          cnt_d = 4'd0;
          st_d  = StFinal;
        end
      end
      StFinal: begin
        rk_idx = 4'd0;
        last   = 1'b1;
        pt_d   = round_out;
        done_d = 1'b1;
        st_d   = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= StIdle;
      cnt_q  <= 4'd0;
      data_q <= '0;
      pt_q   <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      pt_q   <= pt_d;
      done_q <= done_d;
    end
  end

  assign ready     = (st_q == StIdle);
  assign busy      = (st_q != StIdle);
  assign done      = done_q;
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: forward AES-128 encryption and key expansion in the
// bench produce ciphertexts, a cycle-level timing model predicts the handshake.
module tb_aes_inv_round_ctrl;

  localparam int NR = 10;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         ready;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;

  logic [127:0] rkeys [16];
  logic [7:0]   sbox [256];

  int           n_tests;
  int           n_fail;
  int           m_left;
  logic         m_done;
  logic [127:0] m_plain;
  logic [127:0] m_exp;
  logic [127:0] drv_exp;

  aes_inv_round_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ciphertext (ciphertext),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  assign rk = rkeys[rk_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward S-box from log/antilog tables over generator 3.
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h01;
    for (int i = 0; i < 256; i++) lg[i] = 0;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      b = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
                ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [0:3][31:0] kw;
    logic [31:0]      w [44];
    logic [31:0]      t;
    logic [7:0]       rc;
    kw = key;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = kw[i];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rkeys[r] = '0;
    for (int r = 0; r <= NR; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [0:15][7:0] s;
    logic [0:15][7:0] t;
    logic [7:0]       a0, a1, a2, a3;
    s = pt ^ rkeys[0];
    for (int r = 1; r <= NR; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox[s[n]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r != NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ rkeys[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance one clock; the model tracks edges left until the done edge.
  task automatic tick();
    int exp_idx;
    @(posedge clk);
    if (reset) begin
      m_left  = 0;
      m_done  = 1'b0;
      m_plain = '0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left = NR;
          m_exp  = drv_exp;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done  = 1'b1;
          m_plain = m_exp;
        end
      end
    end
    exp_idx = (m_left == 0) ? NR : (m_left == 1) ? 0 : m_left - 1;
    @(negedge clk);
    check("ready", 128'(ready), 128'(m_left == 0));
    check("busy", 128'(busy), 128'(m_left != 0));
    check("done", 128'(done), 128'(m_done));
    check("rk_idx", 128'(rk_idx), 128'(exp_idx));
    check("plaintext", plaintext, m_plain);
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, output int lat);
    expand(key);
    start      = 1'b1;
    ciphertext = ct;
    drv_exp    = pt;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int           lat;
    int           ndone;
    int           guard;
    logic [127:0] key;
    logic [127:0] pt;
    n_tests    = 0;
    n_fail     = 0;
    m_left     = 0;
    m_done     = 1'b0;
    m_plain    = '0;
    m_exp      = '0;
    drv_exp    = '0;
    reset      = 1'b1;
    start      = 1'b0;
    ciphertext = '0;
    build_sbox();
    for (int i = 0; i < 16; i++) rkeys[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Known-answer vectors, second block started in the first one's done cycle.
    run_block(KeyC1, CtC1, PtC1, lat);
    check("c1_latency", 128'(lat), 128'(NR + 1));
    check("c1_plain", plaintext, PtC1);
    run_block(KeyB, CtB, PtB, lat);
    check("b2b_gap", 128'(lat), 128'(NR + 1));
    check("b_plain", plaintext, PtB);
    repeat (3) tick();

    // Starts and ciphertext changes mid-block are ignored.
    expand(KeyC1);
    start      = 1'b1;
    ciphertext = CtC1;
    drv_exp    = PtC1;
    tick();
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      start = (k == 3 || k == 7);
      if (start) begin
        ciphertext = rand128();
        drv_exp    = rand128();
      end
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    check("ignore_done_count", 128'(ndone), 128'(1));
    check("ignore_plain", plaintext, PtC1);

    // Reset mid-block aborts it and clears the result.
    start      = 1'b1;
    ciphertext = CtB;
    drv_exp    = PtB;
    expand(KeyB);
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_plain", plaintext, 128'h0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_done_count", 128'(ndone), 128'(0));
    run_block(KeyC1, CtC1, PtC1, lat);
    check("after_abort_plain", plaintext, PtC1);

    // Reset wins over a simultaneous start.
    reset      = 1'b1;
    start      = 1'b1;
    ciphertext = CtC1;
    drv_exp    = PtC1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) ndone++;
    end
    check("rst_start_done_count", 128'(ndone), 128'(0));

    // Random keys and plaintexts, with junk starts and occasional resets while busy.
    for (int b = 0; b < 40; b++) begin
      repeat ($urandom_range(0, 3)) tick();
      key = rand128();
      pt  = rand128();
      expand(key);
      start      = 1'b1;
      ciphertext = encrypt(pt);
      drv_exp    = pt;
      tick();
      start = 1'b0;
      guard = 0;
      while (m_left != 0 && guard < 30) begin
        start = ($urandom_range(0, 3) == 0);
        if (start) begin
          ciphertext = rand128();
          drv_exp    = rand128();
        end
        reset = ($urandom_range(0, 59) == 0);
        tick();
        guard++;
      end
      start = 1'b0;
      reset = 1'b0;
      if (guard >= 30) check("rand_timeout", 128'(guard), 128'(0));
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
